pad_cfg_spi: RTL and testbench

//  Serial configuration slave inside chip_core, directly downstream of the input pad cells.
//  - Receives SPI mode-0 frames on three input pads: sck, csn, mosi.
//  - Holds the pad-control register bank that drives every bidir pad's oe/cs/sl/ie/pu/pd
//    and every input pad's pu/pd.
//  - Returns read data on one bidir pad (miso) so the bench can read back pad state.

---
 rtl/pad_cfg_pkg.sv | 25 ++
 rtl/sync_edge.sv | 17 +
 rtl/pad_cfg_spi.sv | 104 ++++++++++
 tb/tb_pad_cfg_spi.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// pad_cfg_pkg: frame layout, address map and pad field encodings for pad_cfg_spi
package pad_cfg_pkg;
  localparam int FRAME_LEN = 16;
  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] BIDIR_BASE = 7'h00;
  localparam logic [ADDR_W-1:0] INPUT_BASE = 7'h40;
  localparam logic [ADDR_W-1:0] ID_ADDR = 7'h7F;
  localparam logic [7:0] CHIP_CFG_ID = 8'hA5;
  localparam int OE = 0;
  localparam int CS = 1;
  localparam int SL = 2;
  localparam int IE = 3;
  localparam int PU = 4;
  localparam int PD = 5;
  localparam int IN_PU = 0;
  localparam int IN_PD = 1;
  localparam logic [5:0] BIDIR_RST = 6'b001000;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;
  function automatic logic [5:0] bidir_wr(input logic [5:0] c);
    return {c[PD] & ~c[PU], c[4:0]};
  endfunction
  function automatic logic [1:0] input_wr(input logic [1:0] c);
    return {c[IN_PD] & ~c[IN_PU], c[IN_PU]};
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer with one-cycle rise/fall strobes
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= rst ? {3{RST_VAL}} : {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/pad_cfg_spi.sv
// pad_cfg_spi: SPI mode-0 slave holding the bidir/input pad configuration bank
module pad_cfg_spi
  import pad_cfg_pkg::*;
#(
  parameter int NUM_INPUT_PADS = 12,
  parameter int NUM_BIDIR_PADS = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sck_i,
  input  logic                      csn_i,
  input  logic                      mosi_i,
  output logic                      miso_o,
  output logic                      miso_oe_o,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe_o,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs_o,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl_o,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie_o,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu_o,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd_o,
  output logic [NUM_INPUT_PADS-1:0] input_pu_o,
  output logic [NUM_INPUT_PADS-1:0] input_pd_o
);
  localparam int BW = $clog2(NUM_BIDIR_PADS);
  localparam int IW = $clog2(NUM_INPUT_PADS);
  logic sck_lvl_unused, sck_rise, sck_fall, csn_s, csn_rise, csn_fall, mosi_s;
  logic [1:0] mosi_ff;
  spi_state_t state, nxt;
  logic [4:0] cnt;
  logic [FRAME_LEN-2:0] shreg;
  logic [FRAME_LEN-1:0] frame;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0] rdata, shadow;
  logic step, last, commit;
  logic [NUM_BIDIR_PADS-1:0][5:0] bcfg;
  logic [NUM_INPUT_PADS-1:0][1:0] icfg;

  sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(sck_i), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_csn (
    .clk(clk), .rst(rst), .d(csn_i), .q(csn_s), .rise(csn_rise), .fall(csn_fall)
  );

  always_ff @(posedge clk) mosi_ff <= rst ? 2'b00 : {mosi_ff[0], mosi_i};
  assign mosi_s = mosi_ff[1];

  // frame as it stands including the bit arriving on this rise strobe
  assign frame = {shreg, mosi_s};
  assign rd_addr = frame[ADDR_W-1:0];
  assign wr_addr = frame[14:8];
  assign step = state == SHIFT && sck_rise;
  assign last = step && cnt == 5'd15;
  assign commit = last && !csn_s && !frame[15];

  always_comb begin
    nxt = csn_s ? IDLE : (state == IDLE && csn_fall) ? SHIFT : last ? DONE : state;
    rdata = rd_addr == ID_ADDR ? CHIP_CFG_ID
          : rd_addr < 7'(NUM_BIDIR_PADS) ? {2'b00, bcfg[rd_addr[BW-1:0]]}
          : (rd_addr >= INPUT_BASE && rd_addr < INPUT_BASE + 7'(NUM_INPUT_PADS))
            ? {6'b0, icfg[IW'(rd_addr - INPUT_BASE)]}
          : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      shadow <= '0;
      miso_o <= 1'b0;
      bcfg <= {NUM_BIDIR_PADS{BIDIR_RST}};
      icfg <= '0;
    end else begin
      state <= nxt;
      cnt <= csn_s ? 5'd0 : step ? cnt + 5'd1 : cnt;
      if (step) shreg <= frame[FRAME_LEN-2:0];
      if (step && cnt == 5'd7) shadow <= rdata;
      // cnt 8..15 in SHIFT marks the read window: fall after rise n shows rdata[15-n]
      miso_o <= csn_rise ? 1'b0
              : sck_fall ? (state == SHIFT && cnt[3] && shadow[~cnt[2:0]])
              : miso_o;
      if (commit && wr_addr < 7'(NUM_BIDIR_PADS))
        bcfg[wr_addr[BW-1:0]] <= bidir_wr(frame[5:0]);
      if (commit && wr_addr >= INPUT_BASE && wr_addr < INPUT_BASE + 7'(NUM_INPUT_PADS))
        icfg[IW'(wr_addr - INPUT_BASE)] <= input_wr(frame[1:0]);
    end
  end

  assign miso_oe_o = ~csn_s;

  for (genvar g = 0; g < NUM_BIDIR_PADS; g++) begin : g_bidir
    assign bidir_oe_o[g] = bcfg[g][OE];
    assign bidir_cs_o[g] = bcfg[g][CS];
    assign bidir_sl_o[g] = bcfg[g][SL];
    assign bidir_ie_o[g] = bcfg[g][IE];
    assign bidir_pu_o[g] = bcfg[g][PU];
    assign bidir_pd_o[g] = bcfg[g][PD];
  end
  for (genvar g = 0; g < NUM_INPUT_PADS; g++) begin : g_input
    assign input_pu_o[g] = icfg[g][IN_PU];
    assign input_pd_o[g] = icfg[g][IN_PD];
  end
endmodule

// File: tb/tb_pad_cfg_spi.sv
// tb_pad_cfg_spi: scoreboard bench driving SPI frames at sck = clk/4
module tb_pad_cfg_spi;
  localparam int NB = 40;
  localparam int NI = 12;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic miso, miso_oe;
  logic [NB-1:0] b_oe, b_cs, b_sl, b_ie, b_pu, b_pd;
  logic [NI-1:0] i_pu, i_pd;
  int n_chk = 0, n_fail = 0;
  logic [5:0] bm [NB];
  logic [1:0] im [NI];
  logic [7:0] sb [$];
  logic [7:0] got, exp_v;

  pad_cfg_spi #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB)) dut (
    .clk(clk), .rst(rst), .sck_i(sck), .csn_i(csn), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe),
    .bidir_oe_o(b_oe), .bidir_cs_o(b_cs), .bidir_sl_o(b_sl),
    .bidir_ie_o(b_ie), .bidir_pu_o(b_pu), .bidir_pd_o(b_pd),
    .input_pu_o(i_pu), .input_pd_o(i_pd)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) bm[i] = 6'b001000;
    for (int i = 0; i < NI; i++) im[i] = 2'b00;
  endfunction

  function automatic void model_wr(input logic [6:0] a, input logic [7:0] d);
    int ia = int'(a);
    if (ia < NB) bm[ia] = {d[5] & ~d[4], d[4:0]};
    else if (ia >= 64 && ia < 64 + NI) im[ia-64] = {d[1] & ~d[0], d[0]};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [6:0] a);
    int ia = int'(a);
    if (ia == 127) return 8'hA5;
    if (ia < NB) return {2'b00, bm[ia]};
    if (ia >= 64 && ia < 64 + NI) return {6'b0, im[ia-64]};
    return 8'h00;
  endfunction

  function automatic logic [NB-1:0] bvec(input int f);
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = bm[i][f];
    return v;
  endfunction

  function automatic logic [NI-1:0] ivec(input int f);
    logic [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = im[i][f];
    return v;
  endfunction

  function automatic logic [NB-1:0] dut_b(input int f);
    case (f)
      0: return b_oe;
      1: return b_cs;
      2: return b_sl;
      3: return b_ie;
      4: return b_pu;
      default: return b_pd;
    endcase
  endfunction

  // sends nbits of frame MSB first; miso is sampled late in each high phase
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit hold,
                          output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    #2 csn = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[15-i];
      #20 sck = 1'b1;
      #19 if (i >= 8) rd[15-i] = miso;
      #1 sck = 1'b0;
    end
    #20 mosi = 1'b0;
    if (!hold) begin
      csn = 1'b1;
      #80;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int f = 0; f < 6; f++) begin
      n_chk++;
      if (dut_b(f) !== bvec(f)) begin
        n_fail++;
        $display("FAIL reset_bidir_f%0d got %h exp %h", f, dut_b(f), bvec(f));
      end
    end
    n_chk++;
    if (b_ie !== {NB{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_ie_all got %h", b_ie);
    end
    n_chk++;
    if ({i_pu, i_pd} !== '0) begin
      n_fail++;
      $display("FAIL reset_input got %h/%h exp 0", i_pu, i_pd);
    end
    n_chk++;
    if ({miso, miso_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_miso got %b%b exp 00", miso, miso_oe);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write_bidir();
    model_wr(7'h05, 8'h3F);
    spi_xfer({1'b0, 7'h05, 8'h3F}, 16, 1'b0, got);
    for (int f = 0; f < 6; f++) begin
      n_chk++;
      if (dut_b(f) !== bvec(f)) begin
        n_fail++;
        $display("FAIL wr_bidir_f%0d got %h exp %h", f, dut_b(f), bvec(f));
      end
    end
    n_chk++;
    if ({b_pd[5], b_pu[5], b_ie[5], b_sl[5], b_cs[5], b_oe[5]} !== 6'h1F) begin
      n_fail++;
      $display("FAIL wr_pad5 got %b exp 011111", {b_pd[5], b_pu[5], b_ie[5], b_sl[5], b_cs[5], b_oe[5]});
    end
  endtask

  task automatic test_read();
    logic [6:0] addrs [3] = '{7'h7F, 7'h05, 7'h30};
    logic [7:0] vals [3] = '{8'hA5, 8'h1F, 8'h00};
    for (int k = 0; k < 3; k++) begin
      sb.push_back(vals[k]);
      spi_xfer({1'b1, addrs[k], 8'h00}, 16, 1'b0, got);
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL read_%h got %h exp %h", addrs[k], got, exp_v);
      end
    end
  endtask

  task automatic test_input();
    model_wr(7'h41, 8'h02);
    spi_xfer({1'b0, 7'h41, 8'h02}, 16, 1'b0, got);
    n_chk++;
    if ({i_pd[1], i_pu[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL input_pd1 got pd=%b pu=%b exp pd=1 pu=0", i_pd[1], i_pu[1]);
    end
    sb.push_back(8'h02);
    spi_xfer({1'b1, 7'h41, 8'hFF}, 16, 1'b0, got);
    exp_v = sb.pop_front();
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL input_rd1 got %h exp %h", got, exp_v);
    end
    model_wr(7'h41, 8'h03);
    spi_xfer({1'b0, 7'h41, 8'h03}, 16, 1'b0, got);
    sb.push_back(8'h01);
    spi_xfer({1'b1, 7'h41, 8'h00}, 16, 1'b0, got);
    exp_v = sb.pop_front();
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL input_mutex got %h exp %h", got, exp_v);
    end
    n_chk++;
    if (i_pu !== ivec(0) || i_pd !== ivec(1)) begin
      n_fail++;
      $display("FAIL input_vec got %h/%h exp %h/%h", i_pu, i_pd, ivec(0), ivec(1));
    end
  endtask

  task automatic test_abort();
    spi_xfer({1'b0, 7'h00, 8'h3F}, 10, 1'b0, got);
    n_chk++;
    if ({b_pd[0], b_pu[0], b_ie[0], b_sl[0], b_cs[0], b_oe[0]} !== 6'b001000) begin
      n_fail++;
      $display("FAIL abort_pad0 got %b exp 001000", {b_pd[0], b_pu[0], b_ie[0], b_sl[0], b_cs[0], b_oe[0]});
    end
    model_wr(7'h00, 8'h07);
    spi_xfer({1'b0, 7'h00, 8'h07}, 16, 1'b0, got);
    sb.push_back(exp_rd(7'h00));
    spi_xfer({1'b1, 7'h00, 8'h00}, 16, 1'b0, got);
    exp_v = sb.pop_front();
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL abort_next got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    logic [7:0] d;
    logic rw;
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(3))
        0: a = 7'($urandom_range(NB - 1));
        1: a = 7'(64 + $urandom_range(NI - 1));
        2: a = 7'h7F;
        default: a = 7'($urandom_range(127));
      endcase
      d = 8'($urandom);
      rw = (k % 3 == 2) ? 1'b1 : 1'($urandom);
      if (rw) sb.push_back(exp_rd(a));
      else model_wr(a, d);
      spi_xfer({rw, a, d}, 16, 1'b0, got);
      if (rw) begin
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_rd%0d addr %h got %h exp %h", k, a, got, exp_v);
        end
      end
    end
    for (int f = 0; f < 6; f++) begin
      n_chk++;
      if (dut_b(f) !== bvec(f)) begin
        n_fail++;
        $display("FAIL b2b_bidir_f%0d got %h exp %h", f, dut_b(f), bvec(f));
      end
    end
    n_chk++;
    if (i_pu !== ivec(0) || i_pd !== ivec(1)) begin
      n_fail++;
      $display("FAIL b2b_input got %h/%h exp %h/%h", i_pu, i_pd, ivec(0), ivec(1));
    end
  endtask

  task automatic test_mid_reset();
    model_wr(7'h10, 8'h05);
    spi_xfer({1'b0, 7'h10, 8'h05}, 16, 1'b0, got);
    spi_xfer({1'b0, 7'h11, 8'h3A}, 6, 1'b1, got);
    n_chk++;
    if (miso_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_oe_before got %b exp 1", miso_oe);
    end
    @(negedge clk) rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int f = 0; f < 6; f++) begin
      n_chk++;
      if (dut_b(f) !== bvec(f)) begin
        n_fail++;
        $display("FAIL midrst_bidir_f%0d got %h exp %h", f, dut_b(f), bvec(f));
      end
    end
    n_chk++;
    if ({miso, miso_oe, i_pu, i_pd} !== '0) begin
      n_fail++;
      $display("FAIL midrst_misc got %b%b %h %h exp 0", miso, miso_oe, i_pu, i_pd);
    end
    @(negedge clk) rst = 1'b0;
    csn = 1'b1;
    #100;
    sb.push_back(exp_rd(7'h10));
    spi_xfer({1'b1, 7'h10, 8'h00}, 16, 1'b0, got);
    exp_v = sb.pop_front();
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL midrst_read got %h exp %h", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_write_bidir();
    test_read();
    test_input();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
